fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front-end that sits directly upstream of the combinational cache model.
- Drives the cache read address and read enable, and sequences the PC.
- Absorbs miss stalls and prefetch aborts, and buffers fetched words in a small in-order queue for the decode stage.
- Flushes and redirects on a branch or exception clear from the ALU.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, queue entries (power of two, at least 2).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- o_address  output  32  cache read address; always equals the current fetch PC.
- o_rd_en  output  1  cache read enable.
- i_data  input  32  cache read data; valid in the same cycle as o_rd_en.
- i_hit  input  1  cache hit, same cycle.
- i_miss  input  1  cache miss, same cycle.
- i_abort  input  1  cache prefetch abort, same cycle.
- o_recover  output  1  one-cycle pulse telling the cache to abandon an outstanding miss.
- i_clear_from_alu  input  1  flush and redirect request.
- i_pc_from_alu  input  32  redirect target.
- i_stall  input  1  decode back-pressure.
- o_valid  output  1  queue head is valid.
- o_instr  output  32  instruction at the queue head.
- o_pc  output  32  PC of the queue head.
- o_pabort  output  1  queue head carries a prefetch abort.
- o_miss_count  output  32  present only under FETCH_PERF_CNT_EN.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is synchronous and active-high (i_reset).
- Reset values: pc=RESET_VECTOR, state=FETCH, queue empty, o_valid=0, o_rd_en=0, o_recover=0, o_instr=0, o_pc=0, o_pabort=0.
- FSM states: FETCH, MISS, ABORT_HOLD.
- o_rd_en = (state==FETCH or MISS) and count<DEPTH and !i_clear_from_alu.
- FETCH with o_rd_en high, cache responses:
  - i_hit: push {pc, i_data, abort=0}; pc<=pc+4.
  - i_miss: no push; go to MISS; pc held.
  - i_abort: push {pc, 32'h0, abort=1}; go to ABORT_HOLD; pc held.
- MISS: o_rd_en stays high on the same address. i_hit pushes, increments pc and returns to FETCH. i_abort behaves as in FETCH.
- ABORT_HOLD: o_rd_en=0; no fetch until a clear arrives.
- Cache response priority: if more than one of i_hit/i_miss/i_abort is high, abort > miss > hit.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Queue head and pop:
  - o_valid/o_instr/o_pc/o_pabort reflect the queue head, driven from registers.
  - Pop when o_valid && !i_stall.
  - A push is registered into the queue one cycle after the cache responds.
- Full and empty:
  - Full (count==DEPTH): no fetch, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: count unchanged.
  - Empty: o_valid=0; outputs hold their last value.
- Flush (i_clear_from_alu=1) has priority over everything:
  - Queue emptied, any same-cycle push discarded, pop ignored.
  - pc<={i_pc_from_alu[31:2],2'b00}; state<=FETCH; o_rd_en=0 that cycle.
- Miss during flush: if state==MISS when the flush is taken, o_recover=1 in the following cycle only; otherwise o_recover=0.
- Reset mid-miss: return to reset values; o_recover is not pulsed.
- Misaligned redirect targets are silently aligned by forcing bits [1:0] to zero.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - o_miss_count is present.
  - Increments once per cycle in which o_rd_en && i_miss; saturates at 32'hFFFF_FFFF.
  - Reset clears it to 0; flush does not clear it.
- Not defined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {FETCH, MISS, ABORT_HOLD}.
  - fetch_entry_t struct {pc[31:0], instr[31:0], abort}.
  - Constant INSTR_BYTES=4.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with a DEPTH parameter, push/pop/flush inputs, count/full/empty outputs.

Test Plan:
- Reset, no stall, all hits, mem[0..12] = 0xE3A00001..4 → o_pc sequence 0,4,8,12 with matching o_instr; o_rd_en high from the first cycle after reset.
- i_stall held high, all hits → exactly 4 pushes, then o_rd_en=0 and pc=0x10; release stall → fetching resumes at 0x10.
- i_miss for 3 cycles at 0x8 → o_address stays 0x8 with o_rd_en=1; no queue growth; hit on the 4th cycle → entry {0x8, data} pushed.
- i_abort at 0xC → entry with o_pabort=1 and o_pc=0xC; o_rd_en=0 until a clear; clear to 0x103 → next fetch at 0x100.
- Clear during MISS while the queue is full → o_valid=0 next cycle; o_recover pulses once; o_rd_en=0 in the clear cycle.
- pc=0xFFFF_FFFC with a hit → next o_address=0; with FETCH_PERF_CNT_EN, 5 miss cycles → o_miss_count=5, unchanged after a flush.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch front-end
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    MISS       = 2'd1,
    ABORT_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        abort;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : in-order FIFO of fetch entries with registered head outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int   DEPTH = 4,
  localparam int  AW    = $clog2(DEPTH),
  localparam int  CW    = AW + 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_head;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_after_pop;
  logic [CW-1:0] w_count_next;
  logic          r_valid;
  logic          w_push;
  logic          w_pop;

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_push       = i_push && !i_flush && !o_full;
  assign w_pop        = i_pop && !i_flush && !o_empty;
  assign w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_after_pop  = r_count - CW'(w_pop);
  assign w_count_next = i_flush ? '0 : w_after_pop + CW'(w_push);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // The head register preloads the next visible entry; when the queue drains
  // it keeps the last entry shown.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      if (i_flush) begin
        r_wr_ptr <= r_rd_ptr;
      end else if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_count_next != '0) begin
        r_head <= (w_after_pop == '0) ? i_entry : r_mem[w_rd_next];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : instruction fetch front-end (PC sequencing, miss/abort, queue)
// Optional miss counter port enabled by FETCH_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_address,
  output logic        o_rd_en,
  input  logic [31:0] i_data,
  input  logic        i_hit,
  input  logic        i_miss,
  input  logic        i_abort,
  output logic        o_recover,
  input  logic        i_clear_from_alu,
  input  logic [31:0] i_pc_from_alu,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_pabort
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_miss_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_next;
  logic          r_recover;
  logic          w_rd_en;
  logic          w_take_abort;
  logic          w_take_miss;
  logic          w_take_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_q_valid;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= FETCH;
      r_pc      <= RESET_VECTOR;
      r_recover <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_recover <= i_clear_from_alu && (r_state == MISS);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_rd_en      = !i_reset && (r_state == FETCH || r_state == MISS)
                   && (w_count < CW'(DEPTH)) && !i_clear_from_alu;
    w_take_abort = w_rd_en && i_abort;
    w_take_miss  = w_rd_en && !i_abort && i_miss;
    w_take_hit   = w_rd_en && !i_abort && !i_miss && i_hit;
    w_push       = (w_take_abort || w_take_hit) && !w_full;
    w_entry      = '0;
    w_entry.pc    = r_pc;
    w_entry.instr = w_take_hit ? i_data : 32'h0;
    w_entry.abort = w_take_abort;

    if (i_clear_from_alu) begin
      w_state_next = FETCH;
      w_pc_next    = i_pc_from_alu & ~32'h3;
    end else if (w_take_abort) begin
      w_state_next = ABORT_HOLD;
    end else if (w_take_miss) begin
      w_state_next = MISS;
    end else if (w_take_hit) begin
      w_state_next = FETCH;
      w_pc_next    = r_pc + INSTR_BYTES;
    end
  end

  assign w_pop = !w_empty && !i_stall;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (i_clear_from_alu),
    .o_valid (w_q_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_miss_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_miss_count <= 32'h0;
    end else if (w_rd_en && i_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
      r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_miss_count = r_miss_count;
`endif

  assign o_address = r_pc;
  assign o_rd_en   = w_rd_en;
  assign o_recover = r_recover;
  assign o_valid   = w_q_valid;
  assign o_instr   = w_head.instr;
  assign o_pc      = w_head.pc;
  assign o_pabort  = w_head.abort;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : randomized bench for fetch_unit against a queue-based model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ab;
  } ent_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] o_address;
  logic        o_rd_en;
  logic [31:0] i_data;
  logic        i_hit, i_miss, i_abort;
  logic        o_recover;
  logic        i_clear_from_alu;
  logic [31:0] i_pc_from_alu;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_pabort;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_miss_count;
`endif

  fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .o_address        (o_address),
    .o_rd_en          (o_rd_en),
    .i_data           (i_data),
    .i_hit            (i_hit),
    .i_miss           (i_miss),
    .i_abort          (i_abort),
    .o_recover        (o_recover),
    .i_clear_from_alu (i_clear_from_alu),
    .i_pc_from_alu    (i_pc_from_alu),
    .i_stall          (i_stall),
    .o_valid          (o_valid),
    .o_instr          (o_instr),
    .o_pc             (o_pc),
    .o_pabort         (o_pabort)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_miss_count     (o_miss_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Cache image: word at byte address a is 0xE3A00001 + a/4.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hE3A0_0001 + (a >> 2);
  endfunction

  assign i_data = word_at(o_address);

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  bit          m_halt, m_wait, m_rec;
  ent_t        m_q[$];
  ent_t        m_last;
  logic [31:0] m_mc;
  bit          e_rd;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_halt = 0; m_wait = 0; m_rec = 0; m_mc = 0;
    m_q.delete(); m_last = '0;
  endtask

  task automatic cycle(input bit rst, input bit clr, input logic [31:0] tgt,
                       input bit stl, input bit h, input bit m, input bit a);
    ent_t hd;
    i_reset = rst; i_clear_from_alu = clr; i_pc_from_alu = tgt;
    i_stall = stl; i_hit = h; i_miss = m; i_abort = a;
    @(negedge i_clk);
    e_rd = !rst && !m_halt && (m_q.size() < DEPTH) && !clr;
    hd   = (m_q.size() != 0) ? m_q[0] : m_last;
    chk("rd_en",   {31'b0, o_rd_en},   {31'b0, e_rd});
    chk("address", o_address,          m_pc);
    chk("valid",   {31'b0, o_valid},   {31'b0, (m_q.size() != 0)});
    chk("instr",   o_instr,            hd.instr);
    chk("pc",      o_pc,               hd.pc);
    chk("pabort",  {31'b0, o_pabort},  {31'b0, hd.ab});
    chk("recover", {31'b0, o_recover}, {31'b0, m_rec});
`ifdef FETCH_PERF_CNT_EN
    chk("miss_count", o_miss_count, m_mc);
`endif
    m_last = hd;
    if (rst) begin
      model_reset();
    end else if (clr) begin
      m_rec = m_wait;
      m_q.delete();
      m_pc = {tgt[31:2], 2'b00};
      m_halt = 0; m_wait = 0;
    end else begin
      m_rec = 0;
      if (e_rd && m && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      if (m_q.size() != 0 && !stl) begin
        pop_pc.push_back(o_pc);
        pop_instr.push_back(o_instr);
        void'(m_q.pop_front());
      end
      if (e_rd) begin
        if (a) begin
          m_q.push_back('{pc: m_pc, instr: 32'h0, ab: 1'b1});
          m_halt = 1; m_wait = 0;
        end else if (m) begin
          m_wait = 1;
        end else if (h) begin
          m_q.push_back('{pc: m_pc, instr: word_at(m_pc), ab: 1'b0});
          m_pc = m_pc + 32'd4;
          m_wait = 0;
        end
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1; i_clear_from_alu = 0; i_pc_from_alu = 0;
    i_stall = 0; i_hit = 0; i_miss = 0; i_abort = 0;
    model_reset();
    @(posedge i_clk);
    #1;
    repeat (2) cycle(1, 0, 0, 0, 0, 0, 0);

    // All hits, no stall: first four pops are 0,4,8,12 with matching words.
    pop_pc.delete(); pop_instr.delete();
    repeat (8) cycle(0, 0, 0, 0, 1, 0, 0);
    chk("seq_pop_count", {31'b0, (pop_pc.size() >= 4)}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc",    (pop_pc.size() > k) ? pop_pc[k] : 32'hDEAD_BEEF,    32'(4 * k));
      chk("seq_instr", (pop_instr.size() > k) ? pop_instr[k] : 32'hDEAD_BEEF, 32'hE3A0_0001 + 32'(k));
    end

    // Stalled decode fills the queue and freezes the PC at 0x10.
    cycle(1, 0, 0, 0, 0, 0, 0);
    repeat (7) cycle(0, 0, 0, 1, 1, 0, 0);
    chk("full_address", o_address, 32'h10);
    chk("full_rd_en",   {31'b0, o_rd_en}, 32'd0);
    repeat (4) cycle(0, 0, 0, 0, 1, 0, 0);

    // Three misses at 0x8, then a hit; then an abort at 0xC.
    cycle(1, 0, 0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
    chk("miss_address", o_address, 32'h8);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1, 0, 0);
    chk("abort_pop_pc", (pop_pc.size() != 0) ? pop_pc[$] : 32'hDEAD_BEEF, 32'hC);
    cycle(0, 1, 32'h103, 0, 1, 0, 0);
    chk("redirect_address", o_address, 32'h100);

    // Flush while waiting on a miss pulses recover.
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h200, 0, 0, 1, 0);
    chk("recover_pulse", {31'b0, o_recover}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Misaligned redirect to the top of memory, then wrap on a hit.
    cycle(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("top_address", o_address, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("wrap_address", o_address, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    cycle(1, 0, 0, 0, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h40, 0, 0, 1, 0);
    chk("miss_count_lit", o_miss_count, 32'd5);
`endif

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 15) == 0,
            $urandom,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
